// File: rtl/gpio_event_pkg.sv
// Shared defaults and event record layout for the GPIO event capture block.
package gpio_event_pkg;

  localparam int unsigned GpioWidthDefault = 8;
  localparam int unsigned TsWidthDefault   = 24;
  localparam int unsigned FifoDepthDefault = 16;

  // Field order matches the flat word stored in the event FIFO: {value, mask, ts}.
  typedef struct packed {
    logic [GpioWidthDefault-1:0] value;
    logic [GpioWidthDefault-1:0] mask;
    logic [TsWidthDefault-1:0]   ts;
  } gpio_event_t;

endpackage

// File: rtl/gpio_event_fifo.sv
// First-word-fall-through FIFO; pointers carry an extra wrap bit to tell full from empty.
module gpio_event_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
    rd_en   = pop_i & ~empty_o;
    // When full, a same-edge pop frees the slot being written.
    wr_en   = push_i & (~full_o | rd_en);
    rdata_o = empty_o ? '0 : mem_q[rptr_q[Aw-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (Aw+1)'(1);
      if (rd_en) rptr_q <= rptr_q + (Aw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/gpio_event_capture.sv
// Synchronizes a GPIO bus, timestamps every change and queues {value, mask, ts} events.
module gpio_event_capture
  import gpio_event_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = GpioWidthDefault,
  parameter int unsigned TS_WIDTH   = TsWidthDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [GPIO_WIDTH-1:0] ev_value,
  output logic [GPIO_WIDTH-1:0] ev_mask,
  output logic [TS_WIDTH-1:0]   ev_ts,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clear_overflow
);

  localparam int unsigned EvWidth = 2 * GPIO_WIDTH + TS_WIDTH;

  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [TS_WIDTH-1:0]   ts_q;
  logic [1:0]            prime_cnt_q;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_count_q, drop_count_d;

  logic                  change, push, pop, drop, full, empty;
  logic [EvWidth-1:0]    wdata, rdata;

  // prev only holds a real sample once both sync stages and prev itself have loaded.
  always_comb begin
    change = (prime_cnt_q == 2'd3) && (sync2_q != prev_q);
    pop    = ev_valid & ev_ready;
    push   = change & (~full | pop);
    drop   = change & full & ~pop;
    wdata  = {sync2_q, sync2_q ^ prev_q, ts_q};
  end

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      ts_q         <= '0;
      prime_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      ts_q         <= ts_q + TS_WIDTH'(1);
      if (prime_cnt_q != 2'd3) prime_cnt_q <= prime_cnt_q + 2'd1;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  gpio_event_fifo #(
    .Width (EvWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ev_valid                   = ~empty;
  assign {ev_value, ev_mask, ev_ts} = rdata;
  assign overflow                   = overflow_q;
  assign drop_count                 = drop_count_q;

endmodule

// File: tb/tb_gpio_event_capture.sv
// Directed bench for gpio_event_capture: default instance plus a 4-bit timestamp instance.
module tb_gpio_event_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  gpio_in, gpio_in2;
  logic        ev_ready, ev_ready2, clear_overflow;
  logic        ev_valid, ev_valid2, overflow, overflow2;
  logic [7:0]  ev_value, ev_mask, ev_value2, ev_mask2, drop_count, drop_count2;
  logic [23:0] ev_ts;
  logic [3:0]  ev_ts2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0, t;

  always #5 clk = ~clk;

  gpio_event_capture dut (
    .clk            (clk),
    .resetn         (resetn),
    .gpio_in        (gpio_in),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_value       (ev_value),
    .ev_mask        (ev_mask),
    .ev_ts          (ev_ts),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  gpio_event_capture #(
    .GPIO_WIDTH (8),
    .TS_WIDTH   (4),
    .FIFO_DEPTH (4)
  ) dut_ts4 (
    .clk            (clk),
    .resetn         (resetn),
    .gpio_in        (gpio_in2),
    .ev_valid       (ev_valid2),
    .ev_ready       (ev_ready2),
    .ev_value       (ev_value2),
    .ev_mask        (ev_mask2),
    .ev_ts          (ev_ts2),
    .overflow       (overflow2),
    .drop_count     (drop_count2),
    .clear_overflow (1'b0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    resetn = 1'b0; gpio_in = 8'h00; gpio_in2 = 8'h00;
    ev_ready = 1'b0; ev_ready2 = 1'b0; clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ev_valid, 0);
    check("rst_value", ev_value, 0);
    check("rst_mask", ev_mask, 0);
    check("rst_ts", ev_ts, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    resetn = 1'b1;
    cyc = 0;

    // Single edge: stable before edge 9, written at edge 11 with ts 10.
    repeat (8) tick();
    gpio_in = 8'h01;
    tick(); check("single_lat_e9", ev_valid, 0);
    tick(); check("single_lat_e10", ev_valid, 0);
    tick();
    check("single_valid", ev_valid, 1);
    check("single_value", ev_value, 8'h01);
    check("single_mask", ev_mask, 8'h01);
    check("single_ts", ev_ts, 10);
    repeat (3) tick();
    check("hold_valid", ev_valid, 1);
    check("hold_ts", ev_ts, 10);
    ev_ready = 1'b1;
    tick();
    check("single_popped", ev_valid, 0);

    // Ready held while empty must be ignored; then a multi-bit change.
    repeat (2) tick();
    check("ready_idle", ev_valid, 0);
    t = cyc;
    gpio_in = 8'hF0;
    repeat (3) tick();
    check("multi_valid", ev_valid, 1);
    check("multi_value", ev_value, 8'hF0);
    check("multi_mask", ev_mask, 8'hF1);
    check("multi_ts", ev_ts, t + 2);
    tick();
    check("multi_popped", ev_valid, 0);
    ev_ready = 1'b0;

    // Timestamp wrap on the 4-bit instance: events at ts 14 then 2.
    while (((cyc + 2) % 16) != 14) tick();
    gpio_in2 = 8'h01;
    repeat (4) tick();
    gpio_in2 = 8'h03;
    repeat (3) tick();
    check("wrap_valid", ev_valid2, 1);
    check("wrap_value1", ev_value2, 8'h01);
    check("wrap_ts1", ev_ts2, 14);
    ev_ready2 = 1'b1;
    tick();
    check("wrap_value2", ev_value2, 8'h03);
    check("wrap_mask2", ev_mask2, 8'h02);
    check("wrap_ts2", ev_ts2, 2);
    check("wrap_no_flag", overflow2, 0);
    tick();
    ev_ready2 = 1'b0;
    check("wrap_empty", ev_valid2, 0);

    // Overflow: 17 toggles into a 16-deep FIFO with no consumer.
    c0 = cyc;
    for (int i = 0; i < 17; i++) begin
      gpio_in = gpio_in ^ 8'h01;
      tick();
    end
    repeat (3) tick();
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_count, 1);
    check("ovf_head_value", ev_value, 8'hF1);
    check("ovf_head_ts", ev_ts, c0 + 2);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clr_flag", overflow, 0);
    check("clr_drop", drop_count, 0);

    // Full FIFO: pop and change land on the same edge.
    t = cyc;
    gpio_in = 8'h71;
    repeat (2) tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("fullpop_flag", overflow, 0);
    check("fullpop_drop", drop_count, 0);
    ev_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_value_%0d", i), ev_value, (i % 2 == 0) ? 8'hF1 : 8'hF0);
      check($sformatf("drain_ts_%0d", i), ev_ts, c0 + i + 2);
      tick();
    end
    check("drain_new_value", ev_value, 8'h71);
    check("drain_new_mask", ev_mask, 8'h80);
    check("drain_new_ts", ev_ts, t + 2);
    tick();
    check("drain_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // Reset mid-operation with five events queued and a non-zero bus.
    for (int i = 0; i < 5; i++) begin
      gpio_in = gpio_in ^ 8'h02;
      tick();
    end
    repeat (3) tick();
    check("mid_queued", ev_valid, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", ev_valid, 0);
    check("mid_rst_value", ev_value, 0);
    check("mid_rst_ts", ev_ts, 0);
    repeat (2) tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", i), ev_valid, 0);
    end
    check("post_rst_quiet_ts4", ev_valid2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_event_capture.md
GPIO_EVENT_CAPTURE -- requirements
Module: gpio_event_capture

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 8: width of the monitored GPIO bus; matches the 8-bit gpio_io_o bus.
REQ-002 SHALL have parameter TS_WIDTH, default 24: width of the free-running timestamp.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: event FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock (300 MHz domain); all logic on the rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port gpio_in, input, GPIO_WIDTH: GPIO bus sampled from the upstream stage; asynchronous to clk.
REQ-007 SHALL have port ev_valid, output, 1: the event FIFO head is valid.
REQ-008 SHALL have port ev_ready, input, 1: the consumer accepts the head event.
REQ-009 SHALL have port ev_value, output, GPIO_WIDTH: GPIO value after the change.
REQ-010 SHALL have port ev_mask, output, GPIO_WIDTH: bits that changed.
REQ-011 SHALL have port ev_ts, output, TS_WIDTH: timestamp of the event.
REQ-012 SHALL have port overflow, output, 1: sticky flag, set when an event was dropped.
REQ-013 SHALL have port drop_count, output, 8: number of dropped events; saturates at 255.
REQ-014 SHALL have port clear_overflow, input, 1: synchronous clear of overflow and drop_count.

Function
REQ-015 SHALL pass gpio_in through a two-flop synchronizer (sync1, sync2), then register sync2 into prev.
REQ-016 SHALL detect a change when sync2 != prev; the change mask is sync2 XOR prev.
REQ-017 SHALL generate no event on the first post-reset cycles: prev loads sync2 until the synchronizer is primed (2 cycles).
REQ-018 SHALL increment the timestamp counter every cycle from 0 and wrap from 2^TS_WIDTH-1 to 0 with no flag.
REQ-019 SHALL write {sync2, mask, ts} on the rising edge at which the change is detected; ts is the counter value before that edge.
REQ-020 SHALL give latency: gpio_in stable before edge N gives ev_valid high after edge N+2, when the FIFO is empty.
REQ-021 SHALL use a first-word-fall-through FIFO: ev_value/ev_mask/ev_ts are valid whenever ev_valid is high and hold stable until the transfer.
REQ-022 SHALL count a transfer as ev_valid AND ev_ready on a rising edge; ev_ready while ev_valid is low is ignored.
REQ-023 SHALL NOT deassert ev_valid, or change the payload, without a transfer.
REQ-024 SHALL accept a push when the FIFO is full and a pop occurs on the same edge; occupancy stays FIFO_DEPTH.
REQ-025 SHALL drop the event when the FIFO is full and no pop occurs; overflow is then set and drop_count increments, saturating at 255.
REQ-026 SHALL accept a push and a pop on the same edge when the FIFO is non-empty; occupancy is unchanged.
REQ-027 SHALL give clear_overflow priority over a same-cycle drop: the result is overflow=0, drop_count=0.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-029 SHALL, while resetn=0, clear sync1, sync2, prev, ts, FIFO pointers, overflow and drop_count; ev_valid=0, ev_value=0, ev_mask=0, ev_ts=0.
REQ-030 SHALL discard all queued events when reset asserts mid-operation; the first event after release obeys REQ-017.
REQ-031 SHALL release reset synchronously to clk; an external reset synchronizer is assumed upstream of resetn.

Structure
REQ-032 SHALL place the default parameter values and a packed struct typedef for the event (value, mask, ts) in package gpio_event_pkg.
REQ-033 SHALL implement the storage as sub-module gpio_event_fifo (parameterised on width and depth, FWFT, full/empty outputs).
REQ-034 SHALL keep the synchronizer, change detection, timestamp and overflow logic in gpio_event_capture.

Verification
REQ-035 SHALL check single edge: gpio_in 0x00->0x01 at ts≈10 -> one event value=0x01, mask=0x01, ev_valid 3 edges later.
REQ-036 SHALL check multi-bit: 0x01->0xF0 -> one event value=0xF0, mask=0xF1.
REQ-037 SHALL check overflow: ev_ready=0, 17 toggles with depth 16 -> 16 events retained, overflow=1, drop_count=1; clear_overflow -> both 0.
REQ-038 SHALL check full plus pop: FIFO full, ev_ready=1 and a change on the same edge -> no drop, occupancy stays 16, order preserved.
REQ-039 SHALL check timestamp wrap: TS_WIDTH=4, events at ts 14 and 2 -> ev_ts 14 then 2, no flag.
REQ-040 SHALL check reset mid-operation: 5 queued events, pulse resetn low -> ev_valid=0 immediately and no spurious event after release.
